ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_fifo.sv | 45 ++++
 rtl/ps2_keyboard.sv | 93 +++++++++
 tb/tb_ps2_keyboard.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and the frame validity check used by the receiver.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam logic [7:0] BREAK_PREFIX  = 8'hF0;
  localparam logic [7:0] EXTEND_PREFIX = 8'hE0;

  // shift holds {parity, d7..d0, start}; stop is the bit sampled on the last edge
  function automatic logic frame_ok(input logic [9:0] shift, input logic stop);
    return (shift[0] == 1'b0) && (stop == 1'b1) && (^shift[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO; a push is accepted when full only if a pop happens in the same cycle.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames and queues valid bytes.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic [9:0]    shift;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmr;
  logic          fall;
  logic          frame_valid;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_ok;
  logic          drop;

  assign fall        = clk_s3 & ~clk_s2;
  assign frame_valid = fall && (bit_cnt == LAST_BIT) && frame_ok(shift, dat_s2);
  assign pop_ok      = !nextdata_n && !fifo_empty;
  assign drop        = frame_valid && fifo_full && !pop_ok;
  assign ready       = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_s3   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      tmr      <= '0;
      overflow <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;

      if (fall) begin
        tmr <= TMR_LOAD;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          shift   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shift   <= {dat_s2, shift[9:1]};
        end
      end else if (bit_cnt != '0) begin
        // a stalled partial frame is dropped so the next start bit realigns
        if (tmr == '0) begin
          bit_cnt <= '0;
          shift   <= '0;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end

      if (drop)        overflow <= 1'b1;
      else if (pop_ok) overflow <= 1'b0;
    end
  end

  ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (frame_valid),
    .pop   (!nextdata_n),
    .wdata (shift[8:1]),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks queued bytes and flags.
module tb_ps2_keyboard;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  ps2_keyboard #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk) clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ready !== 1'b0)    $display("FAIL reset_ready: got %b expected 0", ready);    else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow);   else passed++;
    total++; if (data !== 8'h00)    $display("FAIL reset_data: got %h expected 00", data);     else passed++;
  endtask

  task automatic test_single();
    logic [10:0] bits;
    int lat;
    bits = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    @(negedge clk) ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (ready === 1'b1 && lat == 0) lat = k;
    end
    total++;
    if (lat == 0) $display("FAIL single_latency: ready not seen, expected within 4 clk");
    else passed++;
    check8("single_data", data, 8'h1C);
    repeat (6) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    pop_one();
    total++; if (ready !== 1'b0) $display("FAIL single_pop_ready: got %b expected 0", ready); else passed++;
    check8("single_pop_data", data, 8'h00);
  endtask

  task automatic test_sequence();
    send_frame(8'h1C, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h1C, 0, 0, 11);
    check8("seq_0", data, 8'h1C);
    pop_one();
    check8("seq_1", data, 8'hF0);
    pop_one();
    total++; if (ready !== 1'b1) $display("FAIL seq_ready_mid: got %b expected 1", ready); else passed++;
    check8("seq_2", data, 8'h1C);
    pop_one();
    total++; if (ready !== 1'b0) $display("FAIL seq_ready_end: got %b expected 0", ready); else passed++;
  endtask

  task automatic test_bad_frames();
    send_frame(8'h1C, 1, 0, 11);
    total++; if (ready !== 1'b0)    $display("FAIL badpar_ready: got %b expected 0", ready);  else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL badpar_ovf: got %b expected 0", overflow); else passed++;
    send_frame(8'h1C, 0, 1, 11);
    total++; if (ready !== 1'b0)    $display("FAIL badstop_ready: got %b expected 0", ready);  else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL badstop_ovf: got %b expected 0", overflow); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11);
    total++; if (ready !== 1'b1)    $display("FAIL ovf_ready: got %b expected 1", ready);    else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow);  else passed++;
    for (int i = 1; i <= 8; i++) begin
      check8("ovf_pop", data, 8'(i));
      pop_one();
      if (i == 1) begin
        total++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow);
        else passed++;
      end
    end
    total++; if (ready !== 1'b0) $display("FAIL ovf_drained: got %b expected 0", ready); else passed++;
  endtask

  task automatic test_burst_pop();
    send_frame(8'hA5, 0, 0, 11);
    send_frame(8'h5A, 0, 0, 11);
    send_frame(8'h3C, 0, 0, 11);
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk);
    check8("burst_after1", data, 8'h5A);
    @(negedge clk);
    check8("burst_after2", data, 8'h3C);
    @(negedge clk) nextdata_n = 1'b1;
    total++; if (ready !== 1'b0) $display("FAIL burst_ready: got %b expected 0", ready); else passed++;
    check8("burst_empty_data", data, 8'h00);
  endtask

  task automatic test_timeout();
    send_frame(8'h55, 0, 0, 5);
    repeat (TMO + 10) @(negedge clk);
    send_frame(8'h2A, 0, 0, 11);
    check8("tmo_data", data, 8'h2A);
    total++; if (ready !== 1'b1) $display("FAIL tmo_ready: got %b expected 1", ready); else passed++;
    pop_one();
  endtask

  task automatic test_reset_mid();
    send_frame(8'h11, 0, 0, 11);
    send_frame(8'h22, 0, 0, 11);
    send_frame(8'h44, 0, 0, 6);
    @(negedge clk) clrn = 1'b0;
    @(negedge clk) clrn = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b0)    $display("FAIL rstmid_ready: got %b expected 0", ready);  else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rstmid_ovf: got %b expected 0", overflow); else passed++;
    send_frame(8'h33, 0, 0, 11);
    check8("rstmid_data", data, 8'h33);
    total++; if (ready !== 1'b1) $display("FAIL rstmid_next_ready: got %b expected 1", ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_bad_frames();
    test_overflow();
    test_burst_pop();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
